spi_slave_core: RTL and testbench
=================================

// Module: spi_slave_core
// PURPOSE
//  Parametrised, fully synchronous SPI slave for all four SPI modes (CPOL/CPHA).
//  SCLK, SS and MOSI are oversampled in the CLK domain, so no logic runs on SCLK.
//  Supports back-to-back words within one SS frame, a one-word TX holding buffer
//  with ready/load handshake, and a one-cycle RX_VALID strobe per received word.
// PARAMETERS
//  DATA_WIDTH   8   bits per word (>=2)
//  SYNC_STAGES  2   synchroniser flops on SCLK/SS/MOSI (>=2)
//  LSB_FIRST    0   0: MSB shifted first on MOSI/MISO; 1: LSB shifted first
// PORTS
//  CLK          in   1           system clock, rising edge; must be >= 4x SCLK frequency
//  RST          in   1           synchronous reset, active-high
//  CPOL         in   1           SCLK idle level; latched when SS falls
//  CPHA         in   1           0: sample on leading edge; 1: sample on trailing edge; latched when SS falls
//  SCLK         in   1           SPI clock from master (asynchronous)
//  SS           in   1           slave select, active-low (asynchronous)
//  MOSI         in   1           serial data in (asynchronous)
//  MISO         out  1           serial data out; 0 when not selected
//  MISO_OE      out  1           1 while synchronised SS is low
//  TX_DATA      in   DATA_WIDTH  next word to transmit
//  TX_LOAD      in   1           write strobe; accepted only when TX_READY=1
//  TX_READY     out  1           TX holding buffer empty
//  TX_UNDERRUN  out  1           1-cycle pulse: word started with empty buffer
//  RX_DATA      out  DATA_WIDTH  last complete received word; held until the next word completes
//  RX_VALID     out  1           1-cycle pulse: RX_DATA updated
//  BUSY         out  1           1 while the frame is active (synchronised SS low)
// BEHAVIOUR
//  Reset values: MISO=0, MISO_OE=0, TX_READY=1, TX_UNDERRUN=0, RX_DATA=0, RX_VALID=0, BUSY=0.
//  Reset also clears the buffer, shift registers, counters and the config latch; FSM goes to IDLE.
//  RST mid-frame aborts the word; the slave waits for the next SS fall.
//  Input path: SYNC_STAGES flops, then one edge-detect register. Latency from pin to action is SYNC_STAGES+1 CLK.
//  Leading edge: SCLK leaves the CPOL level. Trailing edge: SCLK returns to it.
//  Sample edge: leading if CPHA=0, trailing if CPHA=1. Shift edge: the other edge.
//  FSM IDLE->ACTIVE on synchronised SS fall:
//   - latch CPOL/CPHA
//   - load the TX shift register from the buffer, or from all-zeros with a TX_UNDERRUN pulse if empty
//   - clear the bit counter, set PRIMED, clear RELOAD
//  ACTIVE, sample edge:
//   - shift MOSI into RX shift register, counter+1, clear PRIMED
//   - at count=DATA_WIDTH: RX_DATA<=word and RX_VALID=1 in the next cycle; counter<=0; set RELOAD
//  ACTIVE, shift edge:
//   - PRIMED set: ignore the edge
//   - else RELOAD set: reload the TX shift register from the buffer (underrun rule applies), clear RELOAD
//   - else shift the TX register by one bit
//  MISO is the TX shift register's MSB (LSB_FIRST=0) or LSB (LSB_FIRST=1), gated by MISO_OE.
//  ACTIVE->IDLE on synchronised SS rise (any bit position):
//   - discard the partial RX word: no RX_VALID, RX_DATA unchanged
//   - discard the TX shift contents; the buffer is kept
//  SCLK edges while SS is high are ignored. CPOL/CPHA changes mid-frame are ignored.
//  TX buffer:
//   - TX_LOAD with TX_READY=1 stores TX_DATA; TX_READY=0 from the next cycle
//   - TX_LOAD with TX_READY=0 is ignored
//   - a shift-register load empties the buffer; TX_READY=1 from the next cycle
//   - TX_LOAD and a shift-register load in the same cycle: the old word goes to the shift
//     register, TX_DATA is stored, and TX_READY stays 0
// TESTING
//  T1 mode0, W=8: TX_LOAD 0xA5, master sends 0x3C -> RX_DATA=0x3C, one RX_VALID; master reads 0xA5; TX_READY=1 after SS fall.
//  T2 modes 0-3, LSB_FIRST 0 and 1: TX 0x96, master sends 0x69 -> RX_DATA=0x69, master reads 0x96 in every combination.
//  T3 mode1, one frame of 16 SCLK cycles: load 0x11, reload 0x22 when TX_READY rises -> MISO stream 0x11,0x22; RX_VALID twice.
//  T4 no TX_LOAD before frame -> MISO all zeros, TX_UNDERRUN one pulse at SS fall; RX still captures 0xC3.
//  T5 SS rises after 5 bits -> no RX_VALID, RX_DATA unchanged; next full frame with 0x5A is received correctly.
//  T6 RST at bit 3 -> all outputs at reset values next cycle; TX_LOAD in the same cycle as the word-boundary reload -> TX_READY stays 0.

Source files
------------

// File: rtl/spi_slave_core.sv
// SPI slave, all four CPOL/CPHA modes, fully oversampled in the CLK domain.
// One-word TX holding buffer with ready/load handshake; one-cycle RX_VALID per word.
module spi_slave_core #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LSB_FIRST   = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CPOL,
  input  logic                  CPHA,
  input  logic                  SCLK,
  input  logic                  SS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_OE,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  input  logic                  TX_LOAD,
  output logic                  TX_READY,
  output logic                  TX_UNDERRUN,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  RX_VALID,
  output logic                  BUSY
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH);

  typedef enum logic { IDLE, ACTIVE } state_t;

  state_t                  state_q;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                    sclk_prev_q, ss_prev_q;
  logic                    cpol_q, cpha_q, primed_q, reload_q;
  logic [CW-1:0]           cnt_q;
  logic [DATA_WIDTH-1:0]   tx_sr_q, rx_sr_q, buf_q, rx_data_q;
  logic                    buf_full_q, rx_valid_q, underrun_q;

  logic                    sclk_s, ss_s, mosi_s;
  logic                    ss_fall, ss_rise, lead_edge, trail_edge;
  logic                    active, sample_edge, shift_edge;
  logic                    reload_now, load_sr, buf_accept, word_done;
  logic [CW-1:0]           cnt_d;
  logic [DATA_WIDTH-1:0]   rx_sr_d, tx_shift_d, tx_load_d;
  logic                    miso_bit;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign ss_fall    = ss_prev_q & ~ss_s;
  assign ss_rise    = ~ss_prev_q & ss_s;
  assign lead_edge  = (sclk_s != sclk_prev_q) && (sclk_prev_q == cpol_q);
  assign trail_edge = (sclk_s != sclk_prev_q) && (sclk_s == cpol_q);

  assign active      = (state_q == ACTIVE);
  assign sample_edge = active && !ss_rise && (cpha_q ? trail_edge : lead_edge);
  assign shift_edge  = active && !ss_rise && (cpha_q ? lead_edge : trail_edge);

  assign cnt_d      = cnt_q + CW'(1);
  assign word_done  = sample_edge && (cnt_d == LAST_BIT);
  assign reload_now = shift_edge && !primed_q && reload_q;
  assign load_sr    = (!active && ss_fall) || reload_now;
  // A load coinciding with a shift-register load is always taken: the old word leaves the buffer that cycle.
  assign buf_accept = TX_LOAD && (!buf_full_q || load_sr);
  assign tx_load_d  = buf_full_q ? buf_q : '0;

  always_comb begin
    if (LSB_FIRST != 0) begin
      rx_sr_d    = {mosi_s, rx_sr_q[DATA_WIDTH-1:1]};
      tx_shift_d = {1'b0, tx_sr_q[DATA_WIDTH-1:1]};
      miso_bit   = tx_sr_q[0];
    end else begin
      rx_sr_d    = {rx_sr_q[DATA_WIDTH-2:0], mosi_s};
      tx_shift_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
      miso_bit   = tx_sr_q[DATA_WIDTH-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      // SS sync resets low so a frame already in progress is not mistaken for a fresh SS fall.
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
      state_q     <= IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      primed_q    <= 1'b0;
      reload_q    <= 1'b0;
      cnt_q       <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;

      if (load_sr) buf_full_q <= 1'b0;
      if (buf_accept) begin
        buf_q      <= TX_DATA;
        buf_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_q    <= ACTIVE;
            cpol_q     <= CPOL;
            cpha_q     <= CPHA;
            tx_sr_q    <= tx_load_d;
            underrun_q <= !buf_full_q;
            cnt_q      <= '0;
            primed_q   <= 1'b1;
            reload_q   <= 1'b0;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state_q  <= IDLE;
            tx_sr_q  <= '0;
            cnt_q    <= '0;
            primed_q <= 1'b0;
            reload_q <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_sr_q  <= rx_sr_d;
              primed_q <= 1'b0;
              if (word_done) begin
                rx_data_q  <= rx_sr_d;
                rx_valid_q <= 1'b1;
                cnt_q      <= '0;
                reload_q   <= 1'b1;
              end else begin
                cnt_q <= cnt_d;
              end
            end
            // The first shift edge of a CPHA=1 frame is skipped: the first bit is already on MISO.
            if (shift_edge && !primed_q) begin
              if (reload_q) begin
                tx_sr_q    <= tx_load_d;
                underrun_q <= !buf_full_q;
                reload_q   <= 1'b0;
              end else begin
                tx_sr_q <= tx_shift_d;
              end
            end
          end
        end
      endcase
    end
  end

  assign MISO        = active & miso_bit;
  assign MISO_OE     = active;
  assign BUSY        = active;
  assign TX_READY    = ~buf_full_q;
  assign TX_UNDERRUN = underrun_q;
  assign RX_DATA     = rx_data_q;
  assign RX_VALID    = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Scoreboarded bench for spi_slave_core: an MSB-first and an LSB-first instance
// driven by one SPI master model, with directed scenarios and randomized frames.
module tb_spi_slave_core;
  localparam int W    = 8;
  localparam int HALF = 6;

  logic CLK = 1'b0, RST = 1'b1, CPOL = 1'b0, CPHA = 1'b0, SCLK = 1'b0, SS = 1'b1;
  logic MOSI0 = 1'b0, MOSI1 = 1'b0, TX_LOAD = 1'b0;
  logic [W-1:0] TX_DATA = '0;
  logic MISO0, MISO_OE0, TX_READY0, TX_UNDERRUN0, RX_VALID0, BUSY0;
  logic MISO1, MISO_OE1, TX_READY1, TX_UNDERRUN1, RX_VALID1, BUSY1;
  logic [W-1:0] RX_DATA0, RX_DATA1;

  spi_slave_core #(.DATA_WIDTH(W), .SYNC_STAGES(2), .LSB_FIRST(0)) dut0 (
    .CLK(CLK), .RST(RST), .CPOL(CPOL), .CPHA(CPHA), .SCLK(SCLK), .SS(SS), .MOSI(MOSI0),
    .MISO(MISO0), .MISO_OE(MISO_OE0), .TX_DATA(TX_DATA), .TX_LOAD(TX_LOAD),
    .TX_READY(TX_READY0), .TX_UNDERRUN(TX_UNDERRUN0), .RX_DATA(RX_DATA0),
    .RX_VALID(RX_VALID0), .BUSY(BUSY0));

  spi_slave_core #(.DATA_WIDTH(W), .SYNC_STAGES(2), .LSB_FIRST(1)) dut1 (
    .CLK(CLK), .RST(RST), .CPOL(CPOL), .CPHA(CPHA), .SCLK(SCLK), .SS(SS), .MOSI(MOSI1),
    .MISO(MISO1), .MISO_OE(MISO_OE1), .TX_DATA(TX_DATA), .TX_LOAD(TX_LOAD),
    .TX_READY(TX_READY1), .TX_UNDERRUN(TX_UNDERRUN1), .RX_DATA(RX_DATA1),
    .RX_VALID(RX_VALID1), .BUSY(BUSY1));

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  logic [W-1:0] rx_exp0[$], rx_exp1[$], miso_exp[$], obs0[$], obs1[$];
  logic [W-1:0] load_q[$], late_q[$];
  logic [W-1:0] last_rx = '0;
  logic [W-1:0] hold_data = '0;
  bit hold_en = 0, hold_ready_seen = 0;
  logic ready_after_fall;
  int und0 = 0, und1 = 0, u0s = 0, u1s = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: each complete word is received as sent, and the master reads the buffered word (0 on underrun).
  task automatic expect_word(input logic [W-1:0] rxw, input logic [W-1:0] txw);
    rx_exp0.push_back(rxw);
    rx_exp1.push_back(rxw);
    miso_exp.push_back(txw);
    last_rx = rxw;
  endtask

  // Scoreboard monitor
  always @(negedge CLK) begin
    if (RX_VALID0) begin
      if (rx_exp0.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx0_unexpected_valid: got %0h expected none", RX_DATA0);
      end else check("rx0_data", RX_DATA0, rx_exp0.pop_front());
    end
    if (RX_VALID1) begin
      if (rx_exp1.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx1_unexpected_valid: got %0h expected none", RX_DATA1);
      end else check("rx1_data", RX_DATA1, rx_exp1.pop_front());
    end
    if (TX_UNDERRUN0) und0++;
    if (TX_UNDERRUN1) und1++;
    while (obs0.size() > 0 && obs1.size() > 0) begin
      if (miso_exp.size() == 0) begin
        checks++; errors++;
        $display("FAIL miso_unexpected_word: got %0h expected none", obs0.pop_front());
        void'(obs1.pop_front());
      end else begin
        logic [W-1:0] e;
        e = miso_exp.pop_front();
        check("miso0_word", obs0.pop_front(), e);
        check("miso1_word", obs1.pop_front(), e);
      end
    end
  end

  // TX loader: serves load_q whenever the buffer is free, or holds TX_LOAD for a window.
  always @(negedge CLK) begin
    if (hold_en) begin
      TX_LOAD = 1'b1;
      TX_DATA = hold_data;
      if (TX_READY0) hold_ready_seen = 1;
    end else if (!RST && TX_READY0 && !TX_LOAD && load_q.size() > 0) begin
      TX_LOAD = 1'b1;
      TX_DATA = load_q.pop_front();
    end else begin
      TX_LOAD = 1'b0;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_miso"},     {MISO1, MISO0},         2'b00);
    check({tag, "_miso_oe"},  {MISO_OE1, MISO_OE0},   2'b00);
    check({tag, "_tx_ready"}, {TX_READY1, TX_READY0}, 2'b11);
    check({tag, "_underrun"}, {TX_UNDERRUN1, TX_UNDERRUN0}, 2'b00);
    check({tag, "_rx_data0"}, RX_DATA0, 0);
    check({tag, "_rx_data1"}, RX_DATA1, 0);
    check({tag, "_rx_valid"}, {RX_VALID1, RX_VALID0}, 2'b00);
    check({tag, "_busy"},     {BUSY1, BUSY0},         2'b00);
  endtask

  task automatic run_frame(input int mode, input int nwords, input logic [W-1:0] rxw[4],
                           input int stop_bit, input bit do_rst, input bit flip_cfg,
                           input int hold_lo, input int hold_hi);
    logic cpol, cpha;
    logic [W-1:0] got0, got1;
    bit stopped;
    int gbit;
    cpol = mode[1];
    cpha = mode[0];
    stopped = 0;
    u0s = und0;
    u1s = und1;
    CPOL = cpol; CPHA = cpha; SCLK = cpol;
    repeat (2*HALF) @(negedge CLK);
    SS = 1'b0;
    repeat (HALF) @(negedge CLK);
    ready_after_fall = TX_READY0;
    while (late_q.size() > 0) load_q.push_back(late_q.pop_front());
    if (flip_cfg) begin
      CPOL = ~CPOL;
      CPHA = 1'($urandom);
    end
    for (int k = 0; k < nwords; k++) begin
      got0 = '0;
      got1 = '0;
      for (int i = 0; i < W; i++) begin
        gbit = k*W + i;
        if (gbit == stop_bit) begin
          stopped = 1;
          break;
        end
        hold_en = (gbit >= hold_lo) && (gbit < hold_hi);
        if (!cpha) begin
          MOSI0 = rxw[k][W-1-i];
          MOSI1 = rxw[k][i];
          repeat (HALF) @(negedge CLK);
          got0[W-1-i] = MISO0;
          got1[i] = MISO1;
          SCLK = ~cpol;
          repeat (HALF) @(negedge CLK);
          SCLK = cpol;
        end else begin
          repeat (HALF) @(negedge CLK);
          SCLK = ~cpol;
          MOSI0 = rxw[k][W-1-i];
          MOSI1 = rxw[k][i];
          repeat (HALF) @(negedge CLK);
          got0[W-1-i] = MISO0;
          got1[i] = MISO1;
          SCLK = cpol;
        end
      end
      if (stopped) break;
      obs0.push_back(got0);
      obs1.push_back(got1);
    end
    hold_en = 0;
    if (do_rst) begin
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check_reset("t6_reset_midframe");
      last_rx = '0;
    end
    repeat (HALF) @(negedge CLK);
    SS = 1'b1;
    repeat (3*HALF) @(negedge CLK);
  endtask

  task automatic post_frame(input string tag, input int exp_und);
    check({tag, "_underruns0"}, und0 - u0s, exp_und);
    check({tag, "_underruns1"}, und1 - u1s, exp_und);
    check({tag, "_tx_ready_after"}, {TX_READY1, TX_READY0}, 2'b11);
  endtask

  initial begin
    logic [W-1:0] rxw[4];
    logic [W-1:0] tw[4];
    int mode, n, pre;

    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset("reset");
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    // T1: mode 0, single word
    load_q.push_back(8'hA5);
    rxw[0] = 8'h3C;
    expect_word(8'h3C, 8'hA5);
    run_frame(0, 1, rxw, -1, 0, 0, -1, -1);
    check("t1_ready_after_ss_fall", ready_after_fall, 1);
    post_frame("t1", 1);

    // T2: every mode, both bit orders
    for (int m = 0; m < 4; m++) begin
      load_q.push_back(8'h96);
      rxw[0] = 8'h69;
      expect_word(8'h69, 8'h96);
      run_frame(m, 1, rxw, -1, 0, 0, -1, -1);
      post_frame($sformatf("t2_mode%0d", m), (m % 2 == 0) ? 1 : 0);
    end

    // T3: mode 1, two back-to-back words with reload
    load_q.push_back(8'h11);
    load_q.push_back(8'h22);
    rxw[0] = 8'hE7;
    rxw[1] = 8'h18;
    expect_word(8'hE7, 8'h11);
    expect_word(8'h18, 8'h22);
    run_frame(1, 2, rxw, -1, 0, 0, -1, -1);
    post_frame("t3", 0);

    // T4: underrun, mode 1
    rxw[0] = 8'hC3;
    expect_word(8'hC3, 8'h00);
    run_frame(1, 1, rxw, -1, 0, 0, -1, -1);
    post_frame("t4", 1);

    // T5: abort after 5 bits, then a full frame
    load_q.push_back(8'h4E);
    rxw[0] = 8'hF0;
    run_frame(0, 1, rxw, 5, 0, 0, -1, -1);
    check("t5_rx_data0_held", RX_DATA0, last_rx);
    check("t5_rx_data1_held", RX_DATA1, last_rx);
    post_frame("t5_abort", 0);
    load_q.push_back(8'hB2);
    rxw[0] = 8'h5A;
    expect_word(8'h5A, 8'hB2);
    run_frame(0, 1, rxw, -1, 0, 0, -1, -1);
    post_frame("t5_full", 1);

    // T6a: reset at bit 3
    load_q.push_back(8'h77);
    rxw[0] = 8'h81;
    run_frame(0, 1, rxw, 3, 1, 0, -1, -1);
    check("t6_rx_data0_after", RX_DATA0, 0);
    post_frame("t6a", 0);

    // T6b: TX_LOAD held across the word-boundary reload while the buffer is full
    load_q.push_back(8'hA1);
    load_q.push_back(8'hB2);
    hold_data = 8'hC3;
    hold_ready_seen = 0;
    rxw[0] = 8'h12; rxw[1] = 8'h34; rxw[2] = 8'h56;
    expect_word(8'h12, 8'hA1);
    expect_word(8'h34, 8'hB2);
    expect_word(8'h56, 8'hC3);
    run_frame(0, 3, rxw, -1, 0, 0, 6, 9);
    check("t6_tx_ready_stayed_0", hold_ready_seen, 0);
    post_frame("t6b", 1);

    // Randomized frames
    for (int f = 0; f < 16; f++) begin
      mode = int'($urandom_range(0, 3));
      n    = int'($urandom_range(1, 3));
      pre  = int'($urandom_range(0, 1));
      for (int k = 0; k < n; k++) begin
        rxw[k] = W'($urandom);
        tw[k]  = W'($urandom);
        if (pre != 0) load_q.push_back(tw[k]);
        else if (k > 0) late_q.push_back(tw[k]);
        expect_word(rxw[k], (pre == 0 && k == 0) ? '0 : tw[k]);
      end
      run_frame(mode, n, rxw, -1, 0, 1, -1, -1);
      post_frame($sformatf("rand%0d", f), ((pre != 0) ? 0 : 1) + ((mode % 2 == 0) ? 1 : 0));
    end

    repeat (50) @(negedge CLK);
    check("rx0_queue_drained", rx_exp0.size(), 0);
    check("rx1_queue_drained", rx_exp1.size(), 0);
    check("miso_queue_drained", miso_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
